// File: rtl/window_3x3_gen.sv
// 3x3 sliding-window generator: tracks frame position of each accepted pixel and
// assembles a registered 3x3 neighbourhood from three line-aligned pixel streams.
module window_3x3_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ivalid,
  input  logic                       sof,
  input  logic [WIDTH-1:0]           row0_in,
  input  logic [WIDTH-1:0]           row1_in,
  input  logic [WIDTH-1:0]           row2_in,
  output logic                       ovalid,
  output logic [9*WIDTH-1:0]         window,
  output logic [$clog2(IMG_W)-1:0]   out_x,
  output logic [$clog2(IMG_H)-1:0]   out_y,
  output logic                       oeol,
  output logic                       oeof
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic {FILL, RUN} state_t;
  state_t state_reg, state_next;

  logic [XW-1:0] col_reg, col_next, pos_col;
  logic [YW-1:0] row_reg, row_next, pos_row;
  logic          line_last, frame_last;
  logic          fire, eol_next, eof_next;

  logic [WIDTH-1:0]   line_in  [3];
  logic [WIDTH-1:0]   tap1_reg [3];
  logic [WIDTH-1:0]   tap2_reg [3];
  logic [9*WIDTH-1:0] window_next;

  logic               ovalid_reg, oeol_reg, oeof_reg;
  logic [9*WIDTH-1:0] window_reg;
  logic [XW-1:0]      out_x_reg;
  logic [YW-1:0]      out_y_reg;

  // Position of the pixel on the inputs now; sof relocates it to the frame origin.
  always_comb begin
    pos_col    = sof ? '0 : col_reg;
    pos_row    = sof ? '0 : row_reg;
    line_last  = (pos_col == X_LAST);
    frame_last = line_last && (pos_row == Y_LAST);
    col_next   = col_reg;
    row_next   = row_reg;
    if (ivalid) begin
      col_next = line_last ? '0 : pos_col + 1'b1;
      if (line_last)
        row_next = (pos_row == Y_LAST) ? '0 : pos_row + 1'b1;
      else
        row_next = pos_row;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_reg <= FILL;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ivalid) begin
      case (state_reg)
        FILL:    if (pos_row == YW'(2)) state_next = RUN;
        RUN:     if (sof || frame_last) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // Columns 0 and 1 never emit, so a window cannot straddle two lines.
  always_comb begin
    fire     = ivalid && !sof && (state_reg == RUN) && (col_reg >= XW'(2));
    eol_next = fire && line_last;
    eof_next = fire && frame_last;
  end

  assign line_in[0] = row0_in;
  assign line_in[1] = row1_in;
  assign line_in[2] = row2_in;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        tap1_reg[i] <= '0;
        tap2_reg[i] <= '0;
      end
    end else if (ivalid) begin
      for (int i = 0; i < 3; i++) begin
        tap1_reg[i] <= line_in[i];
        tap2_reg[i] <= tap1_reg[i];
      end
    end
  end

  // Oldest line (row2_in) lands in w0..w2, newest (row0_in) in w6..w8.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      localparam int BASE = (2 - gi) * 3;
      assign window_next[WIDTH*BASE       +: WIDTH] = tap2_reg[gi];
      assign window_next[WIDTH*(BASE + 1) +: WIDTH] = tap1_reg[gi];
      assign window_next[WIDTH*(BASE + 2) +: WIDTH] = line_in[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      ovalid_reg <= 1'b0;
      oeol_reg   <= 1'b0;
      oeof_reg   <= 1'b0;
      window_reg <= '0;
      out_x_reg  <= '0;
      out_y_reg  <= '0;
    end else begin
      ovalid_reg <= fire;
      oeol_reg   <= eol_next;
      oeof_reg   <= eof_next;
      if (fire) begin
        window_reg <= window_next;
        out_x_reg  <= col_reg - 1'b1;
        out_y_reg  <= row_reg - 1'b1;
      end
    end
  end

  assign ovalid = ovalid_reg;
  assign window = window_reg;
  assign out_x  = out_x_reg;
  assign out_y  = out_y_reg;
  assign oeol   = oeol_reg;
  assign oeof   = oeof_reg;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 frame; line-delay taps are modelled
// by feeding row1_in/row2_in with the pixel values one and two lines back.
module tb_window_3x3_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     ivalid;
  logic                     sof;
  logic [WIDTH-1:0]         row0_in, row1_in, row2_in;
  logic                     ovalid;
  logic [9*WIDTH-1:0]       window;
  logic [$clog2(IMG_W)-1:0] out_x;
  logic [$clog2(IMG_H)-1:0] out_y;
  logic                     oeol, oeof;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .sof(sof),
    .row0_in(row0_in), .row1_in(row1_in), .row2_in(row2_in),
    .ovalid(ovalid), .window(window), .out_x(out_x), .out_y(out_y),
    .oeol(oeol), .oeof(oeof)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [71:0] w;
    int          x;
    int          y;
    logic        eol;
    logic        eof;
    int          cyc;
  } win_t;

  win_t win_q[$];
  int   cyc = 0;
  int   acc_cyc [12];
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (ovalid === 1'b1)
      win_q.push_back('{window, int'(out_x), int'(out_y), oeol, oeof, cyc});

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack9(input int v [9]);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = v[k][7:0];
    return r;
  endfunction

  function automatic win_t get_win(input int i);
    win_t z;
    z = '{72'd0, -1, -1, 1'bx, 1'bx, -1};
    if (i < win_q.size()) return win_q[i];
    return z;
  endfunction

  task automatic check_win(input string tag, input int i, input logic [71:0] w,
                           input int x, input int y, input logic eol, input logic eof);
    win_t g;
    g = get_win(i);
    check({tag, ".win"}, g.w, w);
    check({tag, ".x"}, g.x, x);
    check({tag, ".y"}, g.y, y);
    check({tag, ".eol"}, g.eol, eol);
    check({tag, ".eof"}, g.eof, eof);
  endtask

  task automatic drive(input logic v, input logic s, input int d0, input int d1, input int d2);
    @(posedge clock);
    #1;
    ivalid  = v;
    sof     = s;
    row0_in = d0[7:0];
    row1_in = d1[7:0];
    row2_in = d2[7:0];
  endtask

  task automatic idle(input logic s);
    drive(1'b0, s, 8'hEE, 8'hDD, 8'hCC);
  endtask

  // ghost >= 0 inserts an ivalid=0, sof=1 cycle before that pixel index.
  task automatic frame(input int base, input int n, input logic first_sof,
                       input bit gaps, input int ghost);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle(1'b0);
      if (i == ghost) idle(1'b1);
      drive(1'b1, first_sof && (i == 0), base + i,
            (i >= IMG_W) ? base + i - IMG_W : 0,
            (i >= 2*IMG_W) ? base + i - 2*IMG_W : 0);
      if (i < 12) acc_cyc[i] = cyc + 1;
    end
  endtask

  task automatic drain();
    repeat (3) idle(1'b0);
  endtask

  logic [71:0] w_a, w_b;

  initial begin
    w_a = pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10});
    w_b = pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11});
    reset = 1'b0; ivalid = 1'b1; sof = 1'b1;
    row0_in = 8'h55; row1_in = 8'h66; row2_in = 8'h77;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.ovalid", ovalid, 0);
    check("rst.window", window, 0);
    check("rst.out_x", out_x, 0);
    check("rst.out_y", out_y, 0);
    check("rst.oeol", oeol, 0);
    check("rst.oeof", oeof, 0);
    @(posedge clock); #1;
    reset = 1'b1; ivalid = 1'b0; sof = 1'b0;

    // Basic contiguous frame
    win_q.delete();
    frame(0, 12, 1'b1, 1'b0, -1);
    drain();
    check("basic.count", win_q.size(), 2);
    check_win("basic.w0", 0, w_a, 1, 1, 1'b0, 1'b0);
    check_win("basic.w1", 1, w_b, 2, 1, 1'b1, 1'b1);
    check("basic.lat0", get_win(0).cyc, acc_cyc[10]);
    @(negedge clock);
    check("hold.window", window, w_b);
    check("hold.out_x", out_x, 2);
    check("hold.oeol", oeol, 0);
    check("hold.oeof", oeof, 0);

    // Same frame with a gap after every pixel
    win_q.delete();
    frame(0, 12, 1'b1, 1'b1, -1);
    drain();
    check("gap.count", win_q.size(), 2);
    check_win("gap.w0", 0, w_a, 1, 1, 1'b0, 1'b0);
    check_win("gap.w1", 1, w_b, 2, 1, 1'b1, 1'b1);
    check("gap.lat0", get_win(0).cyc, acc_cyc[10]);
    check("gap.lat1", get_win(1).cyc, acc_cyc[11]);

    // Two frames back to back, no sof on the second
    win_q.delete();
    frame(0, 12, 1'b1, 1'b0, -1);
    frame(100, 12, 1'b0, 1'b0, -1);
    drain();
    check("b2b.count", win_q.size(), 4);
    check_win("b2b.w2", 2, pack9('{100, 101, 102, 104, 105, 106, 108, 109, 110}), 1, 1, 1'b0, 1'b0);
    check_win("b2b.w3", 3, pack9('{101, 102, 103, 105, 106, 107, 109, 110, 111}), 2, 1, 1'b1, 1'b1);

    // sof on pixel 6 restarts the frame
    win_q.delete();
    frame(0, 6, 1'b1, 1'b0, -1);
    frame(30, 12, 1'b1, 1'b0, -1);
    drain();
    check("sof6.count", win_q.size(), 2);
    check_win("sof6.w0", 0, pack9('{30, 31, 32, 34, 35, 36, 38, 39, 40}), 1, 1, 1'b0, 1'b0);
    check("sof6.lat0", get_win(0).cyc, acc_cyc[10]);

    // sof while already emitting windows (after pixel 10)
    win_q.delete();
    frame(0, 11, 1'b1, 1'b0, -1);
    frame(50, 12, 1'b1, 1'b0, -1);
    drain();
    check("sofrun.count", win_q.size(), 3);
    check_win("sofrun.w1", 1, pack9('{50, 51, 52, 54, 55, 56, 58, 59, 60}), 1, 1, 1'b0, 1'b0);
    check_win("sofrun.w2", 2, pack9('{51, 52, 53, 55, 56, 57, 59, 60, 61}), 2, 1, 1'b1, 1'b1);

    // Reset after pixel 9, with ivalid/sof active during reset
    win_q.delete();
    frame(0, 10, 1'b1, 1'b0, -1);
    @(posedge clock); #1;
    reset = 1'b0; ivalid = 1'b1; sof = 1'b1; row0_in = 8'h99;
    @(posedge clock); #1;
    reset = 1'b1; ivalid = 1'b0; sof = 1'b0;
    @(negedge clock);
    check("mrst.ovalid", ovalid, 0);
    check("mrst.window", window, 0);
    check("mrst.oeol", oeol, 0);
    frame(200, 12, 1'b0, 1'b0, -1);
    drain();
    check("mrst.count", win_q.size(), 2);
    check_win("mrst.w0", 0, pack9('{200, 201, 202, 204, 205, 206, 208, 209, 210}), 1, 1, 1'b0, 1'b0);
    check("mrst.lat0", get_win(0).cyc, acc_cyc[10]);

    // sof without ivalid mid-line is ignored
    win_q.delete();
    frame(0, 12, 1'b1, 1'b0, 5);
    drain();
    check("ghost.count", win_q.size(), 2);
    check_win("ghost.w0", 0, w_a, 1, 1, 1'b0, 1'b0);
    check_win("ghost.w1", 1, w_b, 2, 1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
